count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_checker.sv | 90 +++++++++
 tb/tb_count_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Continuity checker for an upstream 4-bit counter: locks onto the first
// sample, then flags every step that is not +1 (or a hold, if allowed).
module count_checker #(
  parameter int WRAP_W     = 8,
  parameter bit ALLOW_HOLD = 1'b0
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [3:0]        i_cnt,
  input  logic              i_en,
  input  logic              i_clr,
  output logic              o_locked,
  output logic [WRAP_W-1:0] o_wraps,
  output logic              o_err,
  output logic [7:0]        o_errcnt,
  output logic              o_err_pulse
);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;
  logic [7:0]        errcnt_q, errcnt_d;
  logic              pulse_q, pulse_d;

  logic [3:0] next_exp;
  logic       legal;

  assign next_exp = prev_q + 4'd1;
  assign legal    = (i_cnt == next_exp) || (ALLOW_HOLD && (i_cnt == prev_q));

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    wraps_d  = wraps_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    pulse_d  = 1'b0;
    if (i_clr) begin
      state_d  = ACQ;
      prev_d   = 4'd0;
      wraps_d  = '0;
      err_d    = 1'b0;
      errcnt_d = 8'd0;
    end else if (i_en) begin
      // Every TRACK sample becomes the new reference, legal or not (resync).
      prev_d = i_cnt;
      if (state_q == ACQ) begin
        state_d = TRACK;
      end else if (legal) begin
        if ((prev_q == 4'd15) && (i_cnt == 4'd0)) begin
          wraps_d = wraps_q + WRAP_W'(1);
        end
      end else begin
        err_d   = 1'b1;
        pulse_d = 1'b1;
        if (errcnt_q != 8'hFF) begin
          errcnt_d = errcnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q  <= ACQ;
      prev_q   <= 4'd0;
      wraps_q  <= '0;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      wraps_q  <= wraps_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign o_locked    = (state_q == TRACK);
  assign o_wraps     = wraps_q;
  assign o_err       = err_q;
  assign o_errcnt    = errcnt_q;
  assign o_err_pulse = pulse_q;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: one instance without and one with
// ALLOW_HOLD, both fed the same stimulus and scored against a reference model.
module tb_count_checker;

  logic       CLK;
  logic       RST_X;
  logic [3:0] i_cnt;
  logic       i_en;
  logic       i_clr;

  logic       locked0, err0, pulse0;
  logic [7:0] wraps0, errcnt0;
  logic       locked1, err1, pulse1;
  logic [7:0] wraps1, errcnt1;

  count_checker #(.WRAP_W(8), .ALLOW_HOLD(1'b0)) dut0 (
    .CLK(CLK), .RST_X(RST_X), .i_cnt(i_cnt), .i_en(i_en), .i_clr(i_clr),
    .o_locked(locked0), .o_wraps(wraps0), .o_err(err0),
    .o_errcnt(errcnt0), .o_err_pulse(pulse0)
  );

  count_checker #(.WRAP_W(8), .ALLOW_HOLD(1'b1)) dut1 (
    .CLK(CLK), .RST_X(RST_X), .i_cnt(i_cnt), .i_en(i_en), .i_clr(i_clr),
    .o_locked(locked1), .o_wraps(wraps1), .o_err(err1),
    .o_errcnt(errcnt1), .o_err_pulse(pulse1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       locked;
    logic [7:0] wraps;
    logic       err;
    logic [7:0] errcnt;
    logic       pulse;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state, index 0 = no hold, index 1 = hold allowed.
  int         m_locked[2];
  int         m_prev[2];
  logic [7:0] m_wraps[2];
  logic       m_err[2];
  logic [7:0] m_errcnt[2];
  logic       m_pulse[2];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 0;
      m_prev[k]   = 0;
      m_wraps[k]  = 8'd0;
      m_err[k]    = 1'b0;
      m_errcnt[k] = 8'd0;
      m_pulse[k]  = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic modelStep(input logic en, input logic clr, input int cnt);
    exp_t e;
    bit   legal;
    for (int k = 0; k < 2; k++) begin
      m_pulse[k] = 1'b0;
      if (clr) begin
        m_locked[k] = 0;
        m_wraps[k]  = 8'd0;
        m_err[k]    = 1'b0;
        m_errcnt[k] = 8'd0;
      end else if (en) begin
        if (m_locked[k] == 0) begin
          m_locked[k] = 1;
        end else begin
          legal = (cnt == ((m_prev[k] + 1) % 16)) || (k == 1 && cnt == m_prev[k]);
          if (legal) begin
            if (m_prev[k] == 15 && cnt == 0) m_wraps[k] = m_wraps[k] + 8'd1;
          end else begin
            m_err[k]   = 1'b1;
            m_pulse[k] = 1'b1;
            if (m_errcnt[k] != 8'd255) m_errcnt[k] = m_errcnt[k] + 8'd1;
          end
        end
        m_prev[k] = cnt;
      end
      e.locked = (m_locked[k] != 0);
      e.wraps  = m_wraps[k];
      e.err    = m_err[k];
      e.errcnt = m_errcnt[k];
      e.pulse  = m_pulse[k];
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0) begin
      nChecks++;
      nErrors++;
      $error("[TB] FAIL scoreboard: observed empty queue expected entry");
      return;
    end
    e = q0.pop_front();
    chk("locked0", {7'd0, locked0}, {7'd0, e.locked});
    chk("wraps0",  wraps0,          e.wraps);
    chk("err0",    {7'd0, err0},    {7'd0, e.err});
    chk("errcnt0", errcnt0,         e.errcnt);
    chk("pulse0",  {7'd0, pulse0},  {7'd0, e.pulse});
    e = q1.pop_front();
    chk("locked1", {7'd0, locked1}, {7'd0, e.locked});
    chk("wraps1",  wraps1,          e.wraps);
    chk("err1",    {7'd0, err1},    {7'd0, e.err});
    chk("errcnt1", errcnt1,         e.errcnt);
    chk("pulse1",  {7'd0, pulse1},  {7'd0, e.pulse});
  endtask

  task automatic applyStimulus(input logic en, input logic clr, input int cnt);
    i_en  = en;
    i_clr = clr;
    i_cnt = 4'(cnt);
    modelStep(en, clr, cnt);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  int pulses;

  initial begin
    RST_X = 1'b1;
    i_en  = 1'b0;
    i_clr = 1'b0;
    i_cnt = 4'd0;
    modelReset();
    #2 RST_X = 1'b0;
    #1;
    chk("rst_locked", {7'd0, locked0}, 8'd0);
    chk("rst_wraps",  wraps0,          8'd0);
    chk("rst_err",    {7'd0, err0},    8'd0);
    chk("rst_errcnt", errcnt0,         8'd0);
    chk("rst_pulse",  {7'd0, pulse0},  8'd0);
    @(negedge CLK);
    RST_X = 1'b1;

    // Full run through a wrap.
    for (int i = 0; i < 18; i++) applyStimulus(1'b1, 1'b0, i % 16);
    chk("wrap_wraps",  wraps0,       8'd1);
    chk("wrap_err",    {7'd0, err0}, 8'd0);
    chk("wrap_errcnt", errcnt0,      8'd0);

    // Single jump 4->7, then resynced continuation 8.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 7);
    chk("jump_pulse", {7'd0, pulse0}, 8'd1);
    applyStimulus(1'b1, 1'b0, 8);
    chk("jump_pulse_after", {7'd0, pulse0}, 8'd0);
    chk("jump_errcnt", errcnt0, 8'd1);
    applyStimulus(1'b0, 1'b0, 15);

    // Repeated value: error without hold, legal with hold.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 5);
    chk("hold0_errcnt", errcnt0, 8'd1);
    chk("hold1_errcnt", errcnt1, 8'd0);

    // Illegal jump landing on 0 must not count as a wrap.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b1, 1'b0, 0);
    chk("badwrap_wraps", wraps0, 8'd0);

    // Clear wins over a simultaneous sample, then re-lock cleanly.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 11);
    applyStimulus(1'b1, 1'b1, 9);
    chk("clr_locked", {7'd0, locked0}, 8'd0);
    chk("clr_errcnt", errcnt0,         8'd0);
    chk("clr_err",    {7'd0, err0},    8'd0);
    applyStimulus(1'b1, 1'b0, 9);
    applyStimulus(1'b1, 1'b0, 10);
    chk("relock_locked", {7'd0, locked0}, 8'd1);
    chk("relock_errcnt", errcnt0,         8'd0);

    // Saturation: 300 illegal samples, each separated by an idle cycle.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 0);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 5 : 0);
      if (pulse0) pulses++;
      applyStimulus(1'b0, 1'b0, 0);
    end
    chk("sat_errcnt", errcnt0,      8'd255);
    chk("sat_err",    {7'd0, err0}, 8'd1);
    nChecks++;
    assert (pulses === 300) else begin
      nErrors++;
      $error("[TB] FAIL sat_pulses: observed %0d expected %0d", pulses, 300);
    end

    // Asynchronous reset between edges while an error pulse is showing.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b1, 1'b0, 6);
    chk("pre_rst_pulse", {7'd0, pulse0}, 8'd1);
    #2 RST_X = 1'b0;
    #1;
    chk("arst_locked", {7'd0, locked0}, 8'd0);
    chk("arst_wraps",  wraps0,          8'd0);
    chk("arst_err",    {7'd0, err0},    8'd0);
    chk("arst_errcnt", errcnt0,         8'd0);
    chk("arst_pulse",  {7'd0, pulse0},  8'd0);
    modelReset();
    @(negedge CLK);
    RST_X = 1'b1;
    applyStimulus(1'b1, 1'b0, 9);
    applyStimulus(1'b1, 1'b0, 10);
    chk("post_rst_errcnt", errcnt0, 8'd0);
    chk("post_rst_locked", {7'd0, locked0}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
